// File: rtl/lab5_digit_scroller.sv
// Scrolls a parametrised string of BCD digits onto one active-low
// seven-segment display, one digit per prescaler period.
module lab5_digit_scroller #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV = 50_000_000,
  parameter logic [4*NUM_DIGITS-1:0] DIGITS = 32'h2000_1120,
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank,
  output logic [IW-1:0]           cnt,
  output logic [3:0]              birth_num,
  output logic [6:0]              seg_data,
  output logic                    step,
  output logic                    wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] str;
  logic [IW-1:0]           idx;
  logic [PW-1:0]           pre;
  logic                    tc;
  logic [6:0]              dec;

  assign tc  = (pre == PMAX);
  assign cnt = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      str  <= DIGITS;
      idx  <= '0;
      pre  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      // a coincident terminal count is dropped on purpose
      str  <= load_data;
      idx  <= '0;
      pre  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (!en) begin
      step <= 1'b0;
      wrap <= 1'b0;
    end else if (tc) begin
      pre  <= '0;
      step <= 1'b1;
      if (dir) begin
        if (idx == '0) begin
          idx  <= LAST;
          wrap <= 1'b1;
        end else begin
          idx  <= idx - 1'b1;
          wrap <= 1'b0;
        end
      end else begin
        if (idx == LAST) begin
          idx  <= '0;
          wrap <= 1'b1;
        end else begin
          idx  <= idx + 1'b1;
          wrap <= 1'b0;
        end
      end
    end else begin
      pre  <= pre + 1'b1;
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // index 0 lives in the most significant nibble
  always_comb begin
    birth_num = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) birth_num = str[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  always_comb begin
    dec = 7'b111_1111;
    case (birth_num)
      4'd0: dec = 7'b100_0000;
      4'd1: dec = 7'b111_1001;
      4'd2: dec = 7'b010_0100;
      4'd3: dec = 7'b011_0000;
      4'd4: dec = 7'b001_1001;
      4'd5: dec = 7'b001_0010;
      4'd6: dec = 7'b000_0010;
      4'd7: dec = 7'b111_1000;
      4'd8: dec = 7'b000_0000;
      4'd9: dec = 7'b001_0000;
      default: dec = 7'b111_1111;
    endcase
  end

  assign seg_data = blank ? 7'b111_1111 : dec;

endmodule
